ysyx_24080006_lsq: RTL and testbench

//  In-order load/store request queue that sits directly upstream of the LSU.
//  - Buffers memory ops issued by the EXU dispatch so that dispatch never stalls on a busy LSU.
//  - Presents the oldest op to the LSU through the LSU's exu2lsu_valid/lsu2exu_ready handshake.
//  - Supports a pipeline flush that drops all queued, not-yet-accepted ops.

---
 rtl/ysyx_24080006_lsq.sv | 88 ++++++++
 tb/tb_ysyx_24080006_lsq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_lsq.sv
// In-order load/store request queue in front of the LSU: a circular buffer with
// wrap-bit pointers, a one-cycle push-to-head latency and a flush that drops every queued op.
module ysyx_24080006_lsq #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_addr,
    input  logic [1:0]               in_size,
    input  logic                     in_sext,
    input  logic                     in_write,
    input  logic [31:0]              in_wdata,
    input  logic [IDX_W-1:0]         in_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [1:0]               out_size,
    output logic                     out_sext,
    output logic                     out_write,
    output logic [31:0]              out_wdata,
    output logic [IDX_W-1:0]         out_idx,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    logic [31:0]      addr_mem  [DEPTH];
    logic [1:0]       size_mem  [DEPTH];
    logic             sext_mem  [DEPTH];
    logic             write_mem [DEPTH];
    logic [31:0]      wdata_mem [DEPTH];
    logic [IDX_W-1:0] idx_mem   [DEPTH];

    // in_ready is a pure function of the pointers, so a same-cycle pop never
    // opens a slot for a push when the queue is full.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = wr_ptr - rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Payload storage is never reset; it is only observed through a non-empty head.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr[AW-1:0]]  <= in_addr;
            size_mem[wr_ptr[AW-1:0]]  <= in_size;
            sext_mem[wr_ptr[AW-1:0]]  <= in_sext;
            write_mem[wr_ptr[AW-1:0]] <= in_write;
            wdata_mem[wr_ptr[AW-1:0]] <= in_wdata;
            idx_mem[wr_ptr[AW-1:0]]   <= in_idx;
        end
    end

    assign out_addr  = addr_mem[rd_ptr[AW-1:0]];
    assign out_size  = size_mem[rd_ptr[AW-1:0]];
    assign out_sext  = sext_mem[rd_ptr[AW-1:0]];
    assign out_write = write_mem[rd_ptr[AW-1:0]];
    assign out_wdata = wdata_mem[rd_ptr[AW-1:0]];
    assign out_idx   = idx_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ysyx_24080006_lsq.sv
// Directed bench for the LSU request queue: occupancy, ordering, wrap, flush and reset.
module tb_ysyx_24080006_lsq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [1:0]  in_size = 2'd2;
    logic        in_sext = 1'b0;
    logic        in_write = 1'b0;
    logic [31:0] in_wdata = '0;
    logic [3:0]  in_idx = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [1:0]  out_size;
    logic        out_sext;
    logic        out_write;
    logic [31:0] out_wdata;
    logic [3:0]  out_idx;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    ysyx_24080006_lsq #(.DEPTH(4), .IDX_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_size(in_size), .in_sext(in_sext),
        .in_write(in_write), .in_wdata(in_wdata), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_size(out_size), .out_sext(out_sext),
        .out_write(out_write), .out_wdata(out_wdata), .out_idx(out_idx),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        step();
        step();
        reset = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);

        // Fill with four loads while the LSU stalls
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_addr  = 32'h8000_0000 + 32'(4 * k);
            in_idx   = 4'(k);
            step();
            check("fill_count", 64'(count), 64'(k + 1));
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_addr = 32'h8000_00F0;
        step();
        check("full_reject_count", 64'(count), 64'd4);
        in_valid = 1'b0;
        check("full_head_addr", 64'(out_addr), 64'h8000_0000);
        check("full_head_idx", 64'(out_idx), 64'd0);

        // Drain in order
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_addr", 64'(out_addr), 64'(32'h8000_0000 + 32'(4 * k)));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(out_valid), 64'd0);

        // Simultaneous push and pop at count==2
        in_valid = 1'b1;
        in_addr = 32'h8000_0020; step();
        in_addr = 32'h8000_0024; step();
        check("pp_count_before", 64'(count), 64'd2);
        in_addr = 32'h8000_0010;
        out_ready = 1'b1;
        check("pp_head_first", 64'(out_addr), 64'h8000_0020);
        step();
        in_valid = 1'b0;
        check("pp_count_same", 64'(count), 64'd2);
        check("pp_head_second", 64'(out_addr), 64'h8000_0024);
        step();
        check("pp_third_out", 64'(out_addr), 64'h8000_0010);
        step();
        out_ready = 1'b0;
        check("pp_empty", 64'(count), 64'd0);

        // Ten streaming push/pop pairs across pointer wraps
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                check("wrap_addr", 64'(out_addr), 64'(32'h100 + 32'(4 * (i - 1))));
                check("wrap_count", 64'(count), 64'd1);
            end
            in_addr = 32'h100 + 32'(4 * i);
            step();
        end
        in_valid = 1'b0;
        check("wrap_last_addr", 64'(out_addr), 64'h124);
        step();
        out_ready = 1'b0;
        check("wrap_empty", 64'(count), 64'd0);

        // Flush beats a same-cycle push
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_addr = 32'h200 + 32'(4 * k);
            step();
        end
        check("flush_pre_count", 64'(count), 64'd3);
        flush = 1'b1;
        in_addr = 32'h0000_0BAD;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_addr = 32'h300;
        step();
        in_valid = 1'b0;
        check("flush_next_head", 64'(out_addr), 64'h300);
        check("flush_next_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Store with full field check, misaligned address passed through
        in_valid = 1'b1;
        in_addr  = 32'h8000_0003;
        in_size  = 2'd0;
        in_sext  = 1'b1;
        in_write = 1'b1;
        in_wdata = 32'hDEAD_BEEF;
        in_idx   = 4'd5;
        check("st_no_bypass", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        check("st_out_valid", 64'(out_valid), 64'd1);
        check("st_addr", 64'(out_addr), 64'h8000_0003);
        check("st_size", 64'(out_size), 64'd0);
        check("st_sext", 64'(out_sext), 64'd1);
        check("st_write", 64'(out_write), 64'd1);
        check("st_wdata", 64'(out_wdata), 64'hDEAD_BEEF);
        check("st_idx", 64'(out_idx), 64'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("st_pop_count", 64'(count), 64'd0);
        check("st_pop_valid", 64'(out_valid), 64'd0);

        // Reset mid-operation loses queued entries
        in_valid = 1'b1;
        in_write = 1'b0;
        in_addr = 32'h400; step();
        in_addr = 32'h404; step();
        in_valid = 1'b0;
        check("mid_pre_count", 64'(count), 64'd2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mid_in_ready", 64'(in_ready), 64'd1);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
